// File: rtl/final_schematic_pkg.sv
// Shared constants and helpers for the parking-ticket pricing block.
// Widths, default rates, button weights and the saturating price multiply.
package final_schematic_pkg;

  localparam int unsigned ID_W    = 15;
  localparam int unsigned NUM_IDS = 3;
  localparam int unsigned SN_W    = ID_W * NUM_IDS;
  localparam int unsigned DUR_W   = 4;
  localparam int unsigned VAL_W   = 5;

  localparam int unsigned RATE_A_DEF = 1;
  localparam int unsigned RATE_B_DEF = 2;

  // Duration contributed by each button, in 30-minute units.
  localparam int unsigned W30 = 1;
  localparam int unsigned W1H = 2;
  localparam int unsigned W2H = 4;

  localparam logic [VAL_W-1:0] VAL_MAX = '1;

  // duration * rate, clamped to the largest VAL_W-bit value. Done in 64 bits so
  // any 32-bit rate times a 4-bit duration cannot wrap before the clamp.
  function automatic logic [VAL_W-1:0] satPrice(input logic [DUR_W-1:0] dur,
                                                input int unsigned       rate);
    logic [63:0] prod;
    prod = 64'(dur) * 64'(rate);
    if (prod > 64'(VAL_MAX)) begin
      return VAL_MAX;
    end
    return prod[VAL_W-1:0];
  endfunction

endpackage

// File: rtl/final_schematic_if.sv
// Bus between the pricing block and its environment.
//   master: drives client/button selections, observes the ticket outputs.
//   slave : the pricing block itself.
interface final_schematic_if
  import final_schematic_pkg::*;
();

  logic             ClientA;
  logic             ClientB;
  logic             Button30Min;
  logic             Button1Hour;
  logic             Button2Hours;
  logic [SN_W-1:0]  StudentNumbers;
  logic [DUR_W-1:0] D;
  logic [VAL_W-1:0] ValueToPay;
  logic             P;

  modport master (
    output ClientA, ClientB, Button30Min, Button1Hour, Button2Hours,
    input  StudentNumbers, D, ValueToPay, P
  );

  modport slave (
    input  ClientA, ClientB, Button30Min, Button1Hour, Button2Hours,
    output StudentNumbers, D, ValueToPay, P
  );

endinterface

// File: rtl/final_schematic_price_calc.sv
// Combinational pricing: duration from the additive buttons, client validity,
// and the (saturated) price for the selected client.
// Ports:
//   clientA/clientB           client type selections (exactly one must be set)
//   button30Min/1Hour/2Hours  duration buttons, level-sensitive
//   d                         duration in 30-minute units (0..7, MSB always 0)
//   price                     d * rate of the selected client, clamped to 31
//   valid                     exactly one client and a non-zero duration
module final_schematic_price_calc
  import final_schematic_pkg::*;
#(
  parameter int unsigned RATE_A = RATE_A_DEF,
  parameter int unsigned RATE_B = RATE_B_DEF
) (
  input  logic             clientA,
  input  logic             clientB,
  input  logic             button30Min,
  input  logic             button1Hour,
  input  logic             button2Hours,
  output logic [DUR_W-1:0] d,
  output logic [VAL_W-1:0] price,
  output logic             valid
);

  logic validClient;

  always_comb begin
    d = '0;
    if (button30Min)  d = d + DUR_W'(W30);
    if (button1Hour)  d = d + DUR_W'(W1H);
    if (button2Hours) d = d + DUR_W'(W2H);
  end

  // Both or neither client selected is not a payable selection.
  assign validClient = clientA ^ clientB;
  assign valid       = validClient && (d != '0);

  always_comb begin
    price = '0;
    if (clientA && !clientB) begin
      price = satPrice(d, RATE_A);
    end else if (clientB && !clientA) begin
      price = satPrice(d, RATE_B);
    end
  end

endmodule

// File: rtl/final_schematic.sv
// Parking-ticket pricing block for the bar-code generator.
// Registers duration, amount due and a valid flag one clock after the inputs,
// and drives the constant student-number field for the bar-code encoder.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, clears D/ValueToPay/P
//   bus  slave side of final_schematic_if (selections in, ticket fields out)
module final_schematic
  import final_schematic_pkg::*;
#(
  parameter logic [ID_W-1:0] STUDENT_ID_0 = '0,
  parameter logic [ID_W-1:0] STUDENT_ID_1 = '0,
  parameter logic [ID_W-1:0] STUDENT_ID_2 = '0,
  parameter int unsigned     RATE_A       = RATE_A_DEF,
  parameter int unsigned     RATE_B       = RATE_B_DEF
) (
  input  logic                clk,
  input  logic                rst,
  final_schematic_if.slave    bus
);

  logic [DUR_W-1:0] dCalc;
  logic [VAL_W-1:0] priceCalc;
  logic             validCalc;

  logic [DUR_W-1:0] dQ;
  logic [VAL_W-1:0] valueQ;
  logic             pQ;

  final_schematic_price_calc #(
    .RATE_A (RATE_A),
    .RATE_B (RATE_B)
  ) u_priceCalc (
    .clientA      (bus.ClientA),
    .clientB      (bus.ClientB),
    .button30Min  (bus.Button30Min),
    .button1Hour  (bus.Button1Hour),
    .button2Hours (bus.Button2Hours),
    .d            (dCalc),
    .price        (priceCalc),
    .valid        (validCalc)
  );

  // D always follows the buttons; amount and flag only for a payable selection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dQ     <= '0;
      valueQ <= '0;
      pQ     <= 1'b0;
    end else begin
      dQ     <= dCalc;
      valueQ <= validCalc ? priceCalc : '0;
      pQ     <= validCalc;
    end
  end

  assign bus.D              = dQ;
  assign bus.ValueToPay     = valueQ;
  assign bus.P              = pQ;
  assign bus.StudentNumbers = {STUDENT_ID_0, STUDENT_ID_1, STUDENT_ID_2};

endmodule

// File: tb/tb_final_schematic.sv
// Scoreboard bench: each driven selection pushes the expected ticket for two
// instances (default rates, and large rates that saturate); the entry is popped
// and compared one clock later.
module tb_final_schematic;
  import final_schematic_pkg::*;

  localparam logic [ID_W-1:0] ID0 = 15'd12345;
  localparam logic [ID_W-1:0] ID1 = 15'd23456;
  localparam logic [ID_W-1:0] ID2 = 15'd31007;
  localparam int unsigned     SAT_RA = 5;
  localparam int unsigned     SAT_RB = 20;

  typedef struct packed {
    logic [3:0] d;
    logic [4:0] v0;
    logic       p0;
    logic [4:0] v1;
    logic       p1;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  exp_t expQ[$];
  exp_t last;

  final_schematic_if busDef ();
  final_schematic_if busSat ();

  final_schematic #(
    .STUDENT_ID_0 (ID0),
    .STUDENT_ID_1 (ID1),
    .STUDENT_ID_2 (ID2)
  ) dutDef (
    .clk (clk),
    .rst (rst),
    .bus (busDef)
  );

  final_schematic #(
    .STUDENT_ID_0 (ID2),
    .STUDENT_ID_1 (ID0),
    .STUDENT_ID_2 (ID1),
    .RATE_A       (SAT_RA),
    .RATE_B       (SAT_RB)
  ) dutSat (
    .clk (clk),
    .rst (rst),
    .bus (busSat)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  function automatic exp_t model(input logic a, input logic b, input logic b30,
                                 input logic b1, input logic b2);
    exp_t e;
    int unsigned dur, p0, p1;
    bit ok;
    dur = (b30 ? 1 : 0) + (b1 ? 2 : 0) + (b2 ? 4 : 0);
    ok  = (a != b) && (dur != 0);
    p0  = dur * (a ? 1 : 2);
    p1  = dur * (a ? SAT_RA : SAT_RB);
    if (p1 > 31) p1 = 31;
    e.d  = 4'(dur);
    e.p0 = ok;
    e.v0 = ok ? 5'(p0) : 5'd0;
    e.p1 = ok;
    e.v1 = ok ? 5'(p1) : 5'd0;
    return e;
  endfunction

  task automatic drive(input logic a, input logic b, input logic b30, input logic b1,
                       input logic b2);
    busDef.ClientA = a;   busSat.ClientA = a;
    busDef.ClientB = b;   busSat.ClientB = b;
    busDef.Button30Min = b30;  busSat.Button30Min = b30;
    busDef.Button1Hour = b1;   busSat.Button1Hour = b1;
    busDef.Button2Hours = b2;  busSat.Button2Hours = b2;
    expQ.push_back(model(a, b, b30, b1, b2));
  endtask

  task automatic checkOut(input string tag, input exp_t e);
    checkVal({tag, ".D"}, 64'(busDef.D), 64'(e.d));
    checkVal({tag, ".Val"}, 64'(busDef.ValueToPay), 64'(e.v0));
    checkVal({tag, ".P"}, 64'(busDef.P), 64'(e.p0));
    checkVal({tag, ".satD"}, 64'(busSat.D), 64'(e.d));
    checkVal({tag, ".satVal"}, 64'(busSat.ValueToPay), 64'(e.v1));
    checkVal({tag, ".satP"}, 64'(busSat.P), 64'(e.p1));
  endtask

  // One clock, then compare against the oldest outstanding expectation.
  task automatic stepCheck(input string tag);
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkVal({tag, ".queueEmpty"}, 64'd0, 64'd1);
    end else begin
      last = expQ.pop_front();
      checkOut(tag, last);
    end
  endtask

  initial begin
    exp_t zero;
    zero = '0;
    busDef.ClientA = 1'b1; busDef.ClientB = 1'b0;
    busDef.Button30Min = 1'b1; busDef.Button1Hour = 1'b1; busDef.Button2Hours = 1'b0;
    busSat.ClientA = 1'b1; busSat.ClientB = 1'b0;
    busSat.Button30Min = 1'b1; busSat.Button1Hour = 1'b1; busSat.Button2Hours = 1'b0;

    // 1: reset before any clock edge
    #2;
    checkOut("rstNoEdge", zero);
    checkVal("sn", 64'(busDef.StudentNumbers), 64'({ID0, ID1, ID2}));
    checkVal("snSat", 64'(busSat.StudentNumbers), 64'({ID2, ID0, ID1}));
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOut("rstHeld", zero);
    rst = 1'b0;

    // 2..5: directed cases
    drive(0, 0, 0, 0, 0); stepCheck("allZero");
    drive(0, 1, 1, 1, 1); stepCheck("bAll");
    drive(0, 1, 0, 0, 1);
    #2;
    checkOut("holdBeforeEdge", last);
    stepCheck("b2h");
    drive(1, 0, 1, 1, 0); stepCheck("a30and1h");
    drive(1, 1, 1, 1, 0); stepCheck("bothClients");
    drive(1, 0, 0, 0, 0); stepCheck("aNoButton");
    drive(1, 0, 1, 1, 1); stepCheck("aAll");

    // 6: async reset mid-cycle with a valid selection held
    drive(0, 1, 1, 0, 1); stepCheck("preRst");
    #2 rst = 1'b1;
    #1;
    checkOut("rstAsync", zero);
    checkVal("snRst", 64'(busDef.StudentNumbers), 64'({ID0, ID1, ID2}));
    @(posedge clk); #1;
    checkOut("rstHold", zero);
    #2 rst = 1'b0;
    expQ.push_back(model(0, 1, 1, 0, 1));
    stepCheck("postRst");

    // Random level-sensitive selections
    for (int i = 0; i < 24; i++) begin
      logic [4:0] r;
      r = 5'($urandom_range(0, 31));
      drive(r[0], r[1], r[2], r[3], r[4]);
      stepCheck("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
